mips_control_unit: RTL and testbench

Multicycle MIPS main controller: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back cycles and drives every control input of `Data_Path`. It sits directly upstream of `Data_Path`. It takes the opcode and funct fields from the datapath instruction register and the ALU `Zero` flag. It returns the per-cycle select and write-enable signals.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/mips_control_unit_if.sv | 34 +++
 rtl/mips_control_unit_alu_decoder.sv | 33 +++
 rtl/mips_control_unit.sv | 148 ++++++++++++++
 tb/tb_mips_control_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// States, opcode/funct fields, ALU and ALUSrcB codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW)
        || (op == OP_BEQ) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_control_unit_if.sv
// Controller <-> datapath bundle: IR fields and Zero in,
// per-cycle selects and write enables out.
interface mips_control_unit_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCen;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       PCsrc;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero,
    output PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
    output RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCsrc,
    output Illegal, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
    input  RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCsrc,
    input  Illegal, State
  );
endinterface

// File: rtl/mips_control_unit_alu_decoder.sv
// ALU operation decode: fixed add/sub, or from the R-type funct field.
// Unknown funct codes fall back to add.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctl_o
);

  logic [2:0] funct_ctl;

  always_comb begin
    funct_ctl = ALU_ADD;
    unique case (1'b1)
      (funct_i == F_SUB): funct_ctl = ALU_SUB;
      (funct_i == F_AND): funct_ctl = ALU_AND;
      (funct_i == F_OR):  funct_ctl = ALU_OR;
      (funct_i == F_SLT): funct_ctl = ALU_SLT;
      default:            funct_ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_ctl_o = ALU_ADD;
    unique case (1'b1)
      (alu_op_i == ALUOP_SUB):   alu_ctl_o = ALU_SUB;
      (alu_op_i == ALUOP_FUNCT): alu_ctl_o = funct_ctl;
      default:                   alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// Multicycle MIPS main controller: Moore FSM driving Data_Path
// selects and enables, with the PCen branch gate.
module mips_control_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  mips_control_unit_if.master bus
);

  logic unused_width;
  assign unused_width = ^WIDTH;

  state_t state_q, state_d;
  logic   run_q;
  logic   active;

  logic op_lw, op_sw, op_r, op_beq, op_addi;
  assign op_lw   = (bus.Op == OP_LW);
  assign op_sw   = (bus.Op == OP_SW);
  assign op_r    = (bus.Op == OP_RTYPE);
  assign op_beq  = (bus.Op == OP_BEQ);
  assign op_addi = (bus.Op == OP_ADDI);

  // run_q holds FETCH for the edge that first samples reset high,
  // so FETCH controls start one cycle after release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= run_q ? state_d : FETCH;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          (op_lw | op_sw): state_d = MEMADR;
          op_r:            state_d = EXECUTE;
          op_beq:          state_d = BRANCH;
          op_addi:         state_d = ADDIEX;
          default:         state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = op_sw ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  logic       pcw, br, iord, mw, irw, rd, m2r, rw, sa, pcs;
  logic       alu_en;
  logic [1:0] sb, alu_op;
  logic [2:0] alu_ctl;

  always_comb begin
    pcw    = 1'b0;
    br     = 1'b0;
    iord   = 1'b0;
    mw     = 1'b0;
    irw    = 1'b0;
    rd     = 1'b0;
    m2r    = 1'b0;
    rw     = 1'b0;
    sa     = 1'b0;
    pcs    = 1'b0;
    sb     = SRCB_REG;
    alu_op = ALUOP_ADD;
    alu_en = 1'b0;
    unique case (state_q)
      FETCH: begin
        sb     = SRCB_FOUR;
        alu_en = 1'b1;
        irw    = 1'b1;
        pcw    = 1'b1;
      end
      DECODE: begin
        sb     = SRCB_IMMSH;
        alu_en = 1'b1;
      end
      MEMADR, ADDIEX: begin
        sa     = 1'b1;
        sb     = SRCB_IMM;
        alu_en = 1'b1;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        m2r = 1'b1;
        rw  = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mw   = 1'b1;
      end
      EXECUTE: begin
        sa     = 1'b1;
        alu_op = ALUOP_FUNCT;
        alu_en = 1'b1;
      end
      ALUWB: begin
        rd = 1'b1;
        rw = 1'b1;
      end
      BRANCH: begin
        sa     = 1'b1;
        alu_op = ALUOP_SUB;
        alu_en = 1'b1;
        pcs    = 1'b1;
        br     = 1'b1;
      end
      ADDIWB: rw = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op_i  (alu_op),
    .funct_i   (bus.Funct),
    .alu_ctl_o (alu_ctl)
  );

  assign active = reset & run_q;

  assign bus.PCen       = active & (pcw | (br & bus.Zero));
  assign bus.IorD       = active & iord;
  assign bus.MemWrite   = active & mw;
  assign bus.IRWrite    = active & irw;
  assign bus.RegDst     = active & rd;
  assign bus.MemtoReg   = active & m2r;
  assign bus.RegWrite   = active & rw;
  assign bus.ALUSrcA    = active & sa;
  assign bus.ALUSrcB    = active ? sb : 2'b00;
  assign bus.ALUControl = (active & alu_en) ? alu_ctl : 3'b000;
  assign bus.PCsrc      = active & pcs;
  assign bus.Illegal    = active & (state_q == DECODE)
                        & ~op_legal(bus.Op);
  assign bus.State      = active ? state_q : FETCH;

endmodule

// File: tb/tb_mips_control_unit.sv
// Randomized bench for mips_control_unit against a
// per-instruction state-sequence and control-table model.
module tb_mips_control_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vecs = 0;
  int   miss = 0;

  mips_control_unit_if bus();

  mips_control_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [14:0] got;
  assign got = {bus.PCen, bus.IorD, bus.MemWrite, bus.IRWrite,
                bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUControl, bus.PCsrc, bus.Illegal};

  state_t pseq[5];
  int     plen;

  function automatic logic [14:0] exp_ctl(input state_t s,
      input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic pcw, br, iord, mw, irw, rd, m2r, rw, sa, pcs, ill;
    logic [1:0] sb;
    logic [2:0] ac;
    {pcw, br, iord, mw, irw, rd, m2r, rw, sa, pcs, ill} = '0;
    sb = 2'b00;
    ac = 3'b000;
    case (s)
      FETCH:   begin sb = 2'b01; ac = 3'b010; irw = 1; pcw = 1; end
      DECODE:  begin
        sb = 2'b11;
        ac = 3'b010;
        ill = !(op inside {6'b000000, 6'b100011, 6'b101011,
                           6'b000100, 6'b001000});
      end
      MEMADR:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      MEMRD:   iord = 1;
      MEMWB:   begin m2r = 1; rw = 1; end
      MEMWR:   begin iord = 1; mw = 1; end
      EXECUTE: begin
        sa = 1;
        case (fn)
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
      ALUWB:   begin rd = 1; rw = 1; end
      BRANCH:  begin sa = 1; ac = 3'b110; pcs = 1; br = 1; end
      ADDIEX:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      ADDIWB:  rw = 1;
      default: ;
    endcase
    return {pcw | (br & z), iord, mw, irw, rd, m2r, rw, sa,
            sb, ac, pcs, ill};
  endfunction

  task automatic plan(input logic [5:0] op);
    pseq[0] = FETCH;
    pseq[1] = DECODE;
    case (op)
      6'b100011: begin
        pseq[2] = MEMADR; pseq[3] = MEMRD; pseq[4] = MEMWB; plen = 5;
      end
      6'b101011: begin pseq[2] = MEMADR;  pseq[3] = MEMWR;  plen = 4; end
      6'b000000: begin pseq[2] = EXECUTE; pseq[3] = ALUWB;  plen = 4; end
      6'b001000: begin pseq[2] = ADDIEX;  pseq[3] = ADDIWB; plen = 4; end
      6'b000100: begin pseq[2] = BRANCH; plen = 3; end
      default:   plen = 2;
    endcase
  endtask

  // zmode: 0/1 hold Zero at that value, 2 randomize it each cycle.
  task automatic run_instr(input string tag, input logic [5:0] op,
      input logic [5:0] fn, input bit frand, input int zmode,
      input int steps);
    logic [14:0] e;
    int n;
    plan(op);
    n = (steps > 0 && steps < plen) ? steps : plen;
    for (int i = 0; i < n; i++) begin
      bus.Op    = op;
      bus.Funct = frand ? 6'($urandom) : fn;
      bus.Zero  = (zmode == 2) ? 1'($urandom) : zmode[0];
      @(negedge clk);
      e = exp_ctl(pseq[i], op, bus.Funct, bus.Zero);
      vecs++;
      if ({bus.State, got} !== {pseq[i], e}) begin
        miss++;
        $display("FAIL %s step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b",
                 tag, i, bus.State, got, pseq[i], e);
      end
      vecs++;
      if (!$onehot0({bus.IRWrite, bus.MemWrite, bus.RegWrite})) begin
        miss++;
        $display("FAIL %s_we step %0d: IR/Mem/Reg=%b, expected at most one",
                 tag, i, {bus.IRWrite, bus.MemWrite, bus.RegWrite});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) begin
      bus.Op    = 6'($urandom);
      bus.Funct = 6'($urandom);
      bus.Zero  = 1'($urandom);
      @(negedge clk);
      vecs++;
      if ({bus.State, got} !== 19'd0) begin
        miss++;
        $display("FAIL reset: state=%0d ctl=%b, expected 0/all zero",
                 bus.State, got);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw;
    run_instr("lw", 6'b100011, 6'd0, 1'b1, 2, 0);
  endtask

  task automatic test_sw_rtype;
    run_instr("sw", 6'b101011, 6'd0, 1'b1, 2, 0);
    run_instr("r_sub", 6'b000000, 6'b100010, 1'b0, 2, 0);
    run_instr("r_funct0", 6'b000000, 6'b000000, 1'b0, 2, 0);
  endtask

  task automatic test_beq;
    run_instr("beq_z1", 6'b000100, 6'd0, 1'b1, 1, 0);
    run_instr("beq_z0", 6'b000100, 6'd0, 1'b1, 0, 0);
  endtask

  task automatic test_illegal;
    run_instr("illegal", 6'b111111, 6'd0, 1'b1, 2, 0);
  endtask

  task automatic test_reset_mid;
    run_instr("lw_pre", 6'b100011, 6'd0, 1'b1, 2, 3);
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if ({bus.State, got} !== 19'd0) begin
      miss++;
      $display("FAIL reset_mid: state=%0d ctl=%b, expected 0/all zero",
               bus.State, got);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (bus.State !== 4'(FETCH) || bus.RegWrite !== 1'b0) begin
      miss++;
      $display("FAIL reset_mid_after: state=%0d RegWrite=%b, expected %0d/0",
               bus.State, bus.RegWrite, FETCH);
    end
    @(posedge clk);
    #1;
    run_instr("addi", 6'b001000, 6'd0, 1'b1, 2, 0);
  endtask

  task automatic test_random;
    logic [5:0] ops[5];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000};
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 5) == 5) begin
        op = 6'($urandom);
        while (op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b001000})
          op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 4)];
      end
      run_instr("random", op, 6'd0, 1'b1, 2, 0);
    end
  endtask

  initial begin
    bus.Op    = 6'd0;
    bus.Funct = 6'd0;
    bus.Zero  = 1'b0;
    test_reset();
    test_lw();
    test_sw_rtype();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
